// File: rtl/uart_plpbot_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default sizing and the
// 2-bit encoding of the transmit-handshake state machine.
package uart_plpbot_tx_fifo_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_WAIT_HI = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_plpbot_fifo_mem.sv
// DEPTH x 8 byte storage: registered write on the falling clock edge,
// combinational read so the head entry is always visible to the pop logic.
module uart_plpbot_fifo_mem
  import uart_plpbot_tx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(negedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_plpbot_tx_fifo.sv
// Byte FIFO in front of the UART core: queues pushed bytes and hands them to
// the core one at a time, waiting for a full cts low-then-high cycle between bytes.
module uart_plpbot_tx_fifo
  import uart_plpbot_tx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  input  logic        cts,
  output logic [7:0]  out_buffer,
  output logic        send,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  output logic        busy
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  tx_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [7:0]    r_out;
  logic [7:0]    w_head;
  logic          w_pop, w_push_ok, w_drop;

  assign full  = (r_count == L_DEPTH);
  assign empty = (r_count == '0);

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_pop     = (r_state == ST_IDLE) && !empty && cts;
  assign w_push_ok = wr_en && (!full || w_pop);
  assign w_drop    = wr_en && !w_push_ok;

  uart_plpbot_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_out   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_out <= w_head;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_pop) w_state_nxt = ST_SEND;
      ST_SEND:    w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!cts) w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (cts)  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign send       = (r_state == ST_SEND);
  assign busy       = (r_state != ST_IDLE);
  assign out_buffer = r_out;
  assign count      = r_count;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_uart_plpbot_tx_fifo.sv
// Self-checking bench for uart_plpbot_tx_fifo: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_uart_plpbot_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          cts = 1'b0;
  logic [7:0]    out_buffer;
  logic          send, full, empty, ovf, busy;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_plpbot_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_ovf    (clr_ovf),
    .cts        (cts),
    .out_buffer (out_buffer),
    .send       (send),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes, last loaded byte, and handshake progress.
  logic [7:0] m_q[$];
  logic [7:0] m_out;
  bit         m_ovf, m_active, m_pulse, m_seen_low;
  logic [7:0] sent_q[$];
  int         core_low = 0;
  int         core_len = 10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = 8'h00;
    m_ovf = 0; m_active = 0; m_pulse = 0; m_seen_low = 0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d, input logic clr, input logic c);
    bit pop;
    bit drop;
    pop = !m_active && (m_q.size() != 0) && c;
    if (m_active) begin
      if (m_pulse) m_pulse = 0;
      else if (!m_seen_low) begin
        if (!c) m_seen_low = 1;
      end else if (c) m_active = 0;
    end
    if (pop) begin
      m_out = m_q.pop_front();
      m_active = 1; m_pulse = 1; m_seen_low = 0;
    end
    drop = 0;
    if (we) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_outputs();
    chk("count", count, m_q.size());
    chk("full", full, (m_q.size() == DEPTH));
    chk("empty", empty, (m_q.size() == 0));
    chk("ovf", ovf, m_ovf);
    chk("send", send, m_pulse);
    chk("busy", busy, m_active);
    chk("out_buffer", out_buffer, m_out);
  endtask

  // Inputs change at posedge+1; the DUT updates on the falling edge in between.
  task automatic cycle(input logic we, input logic [7:0] d, input logic clr, input logic c);
    wr_en = we; wr_data = d; clr_ovf = clr; cts = c;
    @(posedge clk); #1;
    model_edge(we, d, clr, c);
    if (send === 1'b1) sent_q.push_back(out_buffer);
    check_outputs();
  endtask

  // Core model: after a send pulse, cts drops for core_len cycles then returns high.
  task automatic core_cycle(input logic we, input logic [7:0] d, input logic clr);
    logic c;
    c = (core_low == 0);
    if (core_low > 0) core_low--;
    cycle(we, d, clr, c);
    if (m_pulse) core_low = core_len;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_send"}, send, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_out"}, out_buffer, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    wr_en = 0; clr_ovf = 0; cts = 0; wr_data = 8'h00;
    rst = 1'b0;
    #1;
    reset_checks(tag);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    core_low = 0;
    sent_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    @(posedge clk); #1;
    do_reset("por");

    // Single byte with the core idle: load one edge later, one-cycle send.
    cycle(1'b1, 8'h41, 1'b0, 1'b1);
    chk("a_count", count, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a_out", out_buffer, 8'h41);
    chk("a_send", send, 1);
    chk("a_empty", empty, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a_send_off", send, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a_idle", busy, 0);

    // Fill while the core is busy, overflow, then clear.
    do_reset("rst_b");
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("b_full", full, 1);
    chk("b_count16", count, 16);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("b_ovf", ovf, 1);
    chk("b_count_hold", count, 16);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("b_ovf_clr", ovf, 0);

    // Full FIFO, push and pop together, then drain.
    sent_q.delete();
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("c_count", count, 16);
    chk("c_ovf", ovf, 0);
    core_len = 10;
    core_low = 10;
    for (int i = 0; i < 400 && (m_q.size() != 0 || m_active); i++) core_cycle(1'b0, 8'h00, 1'b0);
    chk("c_nsent", sent_q.size(), 17);
    if (sent_q.size() == 17) begin
      chk("c_first", sent_q[0], 8'h00);
      chk("c_last", sent_q[16], 8'hAA);
    end

    // Twenty bytes through the core model; pointers wrap past DEPTH.
    do_reset("rst_d");
    pushed = 0;
    for (int i = 0; i < 800; i++) begin
      logic we;
      if (pushed == 20 && m_q.size() == 0 && !m_active) break;
      we = (pushed < 20) && (m_q.size() < 12);
      core_cycle(we, 8'(pushed), 1'b0);
      if (we) pushed++;
    end
    chk("d_nsent", sent_q.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < sent_q.size()) chk("d_order", sent_q[i], 8'(i));

    // Random traffic: core-model cts first, then arbitrary cts.
    do_reset("rst_e");
    for (int i = 0; i < 700; i++) begin
      logic we, clr;
      logic [7:0] d;
      we  = ($urandom % 3) == 0;
      d   = 8'($urandom);
      clr = ($urandom % 8) == 0;
      if (i < 350) begin
        core_len = $urandom_range(1, 4);
        core_cycle(we, d, clr);
      end else begin
        cycle(we, d, clr, 1'($urandom % 2));
      end
    end

    // Reset mid-frame with bytes queued.
    do_reset("rst_f");
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    chk("f_count5", count, 5);
    chk("f_busy", busy, 1);
    chk("f_send", send, 0);
    #2;
    rst = 1'b0;
    #1;
    reset_checks("f_async");
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    sent_q.delete();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("f_no_send", sent_q.size(), 0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("f_new_send", send, 1);
    chk("f_new_out", out_buffer, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_plpbot_tx_fifo.md
UART_PLPBOT_TX_FIFO -- requirements
Module: uart_plpbot_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; equals log2(DEPTH).
REQ-003 clk  input  1  Block clock; all state updates on the negative edge, matching the uart core.
REQ-004 rst  input  1  Reset; asynchronous, active-low.
REQ-005 wr_en  input  1  Push strobe; one byte is pushed per sampled edge.
REQ-006 wr_data  input  8  Byte to enqueue.
REQ-007 clr_ovf  input  1  Clears the overflow flag.
REQ-008 cts  input  1  Clear-to-send from the uart core; 1 means the core is idle.
REQ-009 out_buffer  output  8  Byte presented to the uart core; held stable until the next load.
REQ-010 send  output  1  Single-cycle transmit-start pulse to the uart core.
REQ-011 full, empty  output  1 each  FIFO occupancy flags.
REQ-012 count  output  AW+1  Number of queued bytes, 0..DEPTH; excludes the byte in out_buffer.
REQ-013 ovf  output  1  Sticky flag; set when a push is dropped.
REQ-014 busy  output  1  High whenever the FSM is not in IDLE.

Function
REQ-015 Storage is a circular buffer with AW-bit read and write pointers that wrap modulo DEPTH; count is a separate AW+1-bit register.
REQ-016 full = (count == DEPTH); empty = (count == 0); both are combinational from count.
REQ-017 A push with full = 0 writes wr_data at the write pointer, advances the write pointer, and increments count.
REQ-018 A push with full = 1 is dropped: storage and pointers are unchanged, and ovf is set on the same edge.
REQ-019 Push and pop on the same edge:
- both take effect and count is unchanged;
- when full, the push is accepted (no ovf) because the pop frees a slot.
REQ-020 ovf clears on an edge with clr_ovf = 1, unless a dropped push occurs on that same edge, in which case ovf stays 1.
REQ-021 FSM states: IDLE, SEND, WAIT_LO, WAIT_HI.
REQ-022 IDLE: when empty = 0 and cts = 1, pop the head into out_buffer and go to SEND; otherwise stay in IDLE.
REQ-023 SEND: send = 1 for exactly this one cycle; go to WAIT_LO unconditionally.
REQ-024 WAIT_LO: stay until cts = 0, then go to WAIT_HI.
REQ-025 WAIT_HI: stay until cts = 1, then go to IDLE.
REQ-026 send is 0 in every state except SEND.
REQ-027 Latency: a push into an empty FIFO at edge N, with cts = 1 and FSM in IDLE, loads out_buffer at edge N+1, and send is high between edges N+1 and N+2.
REQ-028 A pushed byte never bypasses storage; the pop always reads the registered head entry.
REQ-029 Back-to-back bytes are separated by a full cts low-then-high cycle, so no byte is overwritten mid-frame.
REQ-030 out_buffer changes only on a pop in IDLE.

Reset
REQ-031 While rst = 0, the following hold regardless of clk:
- pointers = 0, count = 0, ovf = 0;
- FSM = IDLE, send = 0, out_buffer = 8'h00.
REQ-032 Reset asserted mid-frame aborts the FIFO contents and the FSM; storage array contents need not be cleared.
REQ-033 On reset release, the first active edge operates normally; no dummy send is issued.

Structure
REQ-034 FSM state encodings (2-bit) and the default DEPTH belong in a shared uart package.
REQ-035 One sub-module is natural: uart_plpbot_fifo_mem, the DEPTH x 8 storage array with a registered write and a combinational read; the FSM and pointers stay in the top module.

Verification
REQ-036 Reset, push 8'h41 with cts = 1 -> out_buffer = 8'h41 at edge 1 after the push, one-cycle send at edge 2, empty = 1.
REQ-037 Push 16 bytes 8'h00..8'h0F while cts is held 0 -> full = 1, count = 16; a 17th push 8'hFF -> ovf = 1 and count stays 16; clr_ovf -> ovf = 0.
REQ-038 Bench core model (cts low for 10 cycles after send) plus 20 pushes -> 20 sends, order 8'h00..8'h13 preserved, pointers wrap, exactly one send per cts low-high cycle.
REQ-039 FIFO full, simultaneous push of 8'hAA and pop -> count remains 16, ovf = 0, 8'hAA is delivered last.
REQ-040 rst = 0 asserted in WAIT_LO with 5 bytes queued -> count = 0, send = 0, FSM = IDLE immediately; after release, no send until a new push.
